// File: rtl/fusion_pkg.sv
// Shared constants, element/accumulator types, scheduler state encoding and
// the ReLU + 16-bit saturation helper for the fusion compression layer.
package fusion_pkg;

  localparam int INPUT_SIZE  = 96;
  localparam int OUTPUT_SIZE = 128;
  localparam int BIT_WIDTH   = 16;
  localparam int ACC_WIDTH   = 38;
  localparam int W_ADDR_W    = 14;
  localparam int B_ADDR_W    = 7;
  localparam int COL_W       = 7;   // holds 0..INPUT_SIZE-1
  localparam int ROW_W       = 7;   // holds 0..OUTPUT_SIZE-1
  localparam int PROD_W      = 2 * BIT_WIDTH;

  typedef logic signed [BIT_WIDTH-1:0] elem_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_OUT
  } sched_state_e;

  localparam acc_t  SAT_MAX_ACC  = acc_t'(32767);
  localparam elem_t SAT_MAX_ELEM = {1'b0, {(BIT_WIDTH-1){1'b1}}};

  // Negative or zero clamps to 0, large positive clamps to 32767.
  function automatic elem_t relu_sat16(input acc_t acc);
    elem_t res;
    if (acc[ACC_WIDTH-1] || (acc == '0)) begin
      res = '0;
    end else if (acc > SAT_MAX_ACC) begin
      res = SAT_MAX_ELEM;
    end else begin
      res = acc[BIT_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fusion_mac_lane.sv
// Single MAC lane. The scheduler issues SRAM reads; this lane delays the issue
// info by one cycle to line up with the returning SRAM data, multiplies the
// selected input element by the weight and accumulates, seeding the
// accumulator with the sign-extended bias on the first beat of each row.
module fusion_mac_lane
  import fusion_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            issue_valid,
  input  logic                            issue_first,
  input  logic [COL_W-1:0]                issue_col,
  input  logic [INPUT_SIZE*BIT_WIDTH-1:0] x_flat,
  input  elem_t                           w_data,
  input  elem_t                           b_data,
  output acc_t                            acc
);

  logic              data_valid;
  logic              data_first;
  logic [COL_W-1:0]  data_col;
  elem_t             x_sel;
  logic signed [PROD_W-1:0] prod;
  acc_t              prod_ext;
  acc_t              bias_ext;

  // Data-phase pipeline: the issue info one cycle later, aligned with SRAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      data_first <= 1'b0;
      data_col   <= '0;
    end else begin
      data_valid <= issue_valid;
      data_first <= issue_first;
      data_col   <= issue_col;
    end
  end

  // Full signed 16x16 product, sign-extended to accumulator width.
  always_comb begin
    x_sel    = x_flat[data_col*BIT_WIDTH +: BIT_WIDTH];
    prod     = PROD_W'(x_sel) * PROD_W'(w_data);
    prod_ext = ACC_WIDTH'(prod);
    bias_ext = ACC_WIDTH'(b_data);
  end

  // Accumulator: clear on new tensor, load bias+product on row start, else add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (data_valid) begin
      if (data_first) begin
        acc <= bias_ext + prod_ext;
      end else begin
        acc <= acc + prod_ext;
      end
    end
  end

endmodule

// File: rtl/fusion_mac_scheduler.sv
// Time-multiplexed sequencer for the fusion compression layer: one MAC
// computes 128 rows of 96 products each, streaming weights and biases from
// external synchronous SRAMs, then presents the ReLU/saturated result vector.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in OUT, and
// fused_tensor stays constant while out_valid is high and out_ready is low.
module fusion_mac_scheduler
  import fusion_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INPUT_SIZE*BIT_WIDTH-1:0]  raw_tensor,
  output logic                             w_rd_en,
  output logic [W_ADDR_W-1:0]              w_addr,
  input  elem_t                            w_data,
  output logic                             b_rd_en,
  output logic [B_ADDR_W-1:0]              b_addr,
  input  elem_t                            b_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUTPUT_SIZE*BIT_WIDTH-1:0] fused_tensor,
  output logic                             busy
);

  sched_state_e                     state;
  sched_state_e                     state_nxt;
  logic [ROW_W-1:0]                 row;
  logic [COL_W-1:0]                 col;
  logic [INPUT_SIZE*BIT_WIDTH-1:0]  x_regs;
  logic [OUTPUT_SIZE*BIT_WIDTH-1:0] out_vec;
  logic                             accept;
  logic                             last_col;
  logic                             last_row;
  acc_t                             acc;

  assign last_col = (col == COL_W'(INPUT_SIZE - 1));
  assign last_row = (row == ROW_W'(OUTPUT_SIZE - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> (MAC x96 -> DRAIN -> WRITE) x128 -> OUT -> IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        if (last_col) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_row ? S_OUT : S_MAC;
      S_OUT: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake, status and SRAM read-port outputs decoded from state/counters.
  // in_ready is masked by rst_n so every output reads 0 while reset is held.
  always_comb begin
    in_ready  = rst_n && (state == S_IDLE);
    busy      = (state != S_IDLE);
    out_valid = (state == S_OUT);
    w_rd_en   = (state == S_MAC);
    b_rd_en   = (state == S_MAC) && (col == '0);
    w_addr    = '0;
    b_addr    = '0;
    if (w_rd_en) begin
      w_addr = W_ADDR_W'(row) * W_ADDR_W'(INPUT_SIZE) + W_ADDR_W'(col);
    end
    if (b_rd_en) begin
      b_addr = B_ADDR_W'(row);
    end
  end

  // Row/column counters: column walks 0..95 in MAC, row advances in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      row <= '0;
      col <= '0;
    end else if (state == S_MAC) begin
      col <= last_col ? '0 : col + COL_W'(1);
    end else if ((state == S_WRITE) && !last_row) begin
      row <= row + ROW_W'(1);
      col <= '0;
    end
  end

  // Input capture on the accepting handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_regs <= '0;
    end else if (accept) begin
      x_regs <= raw_tensor;
    end
  end

  // Result rows are written in place as each row finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vec <= '0;
    end else if (state == S_WRITE) begin
      out_vec[row*BIT_WIDTH +: BIT_WIDTH] <= relu_sat16(acc);
    end
  end

  assign fused_tensor = out_vec;

  fusion_mac_lane u_lane (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (accept),
    .issue_valid (w_rd_en),
    .issue_first (b_rd_en),
    .issue_col   (col),
    .x_flat      (x_regs),
    .w_data      (w_data),
    .b_data      (b_data),
    .acc         (acc)
  );

endmodule
